// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//  - Internal opcode encodings used by the AGEX->MEM interface.
//  - Memory-access classification (enum + helper) and the register-write rule.
//  - MMIO page/offset constants used when MEM_MMIO_EN is defined.
package mem_stage_pkg;

  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_LW   = 6'h10;
  localparam logic [5:0] OP_SW   = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h20;
  localparam logic [5:0] OP_BNE  = 6'h21;
  localparam logic [5:0] OP_BLT  = 6'h22;
  localparam logic [5:0] OP_BGE  = 6'h23;
  localparam logic [5:0] OP_BLTU = 6'h24;
  localparam logic [5:0] OP_BGEU = 6'h25;
  localparam logic [5:0] OP_JR   = 6'h30;
  localparam logic [5:0] OP_JAL  = 6'h31;

  // MMIO page is memaddr[31:12]; offsets are word offsets within the page.
  localparam logic [19:0] MMIO_PAGE      = 20'hFFFFF;
  localparam logic [9:0]  MMIO_HEX_WOFS  = 10'h000;  // 0xFFFFF000
  localparam logic [9:0]  MMIO_LEDR_WOFS = 10'h008;  // 0xFFFFF020
  localparam logic [9:0]  MMIO_KEY_WOFS  = 10'h020;  // 0xFFFFF080

  typedef enum logic [1:0] {ACC_NONE, ACC_LOAD, ACC_STORE} mem_acc_e;
  typedef enum logic [1:0] {MMIO_NONE, MMIO_HEX, MMIO_LEDR, MMIO_KEY} mmio_sel_e;

  function automatic mem_acc_e mem_acc(input logic [5:0] op);
    if (op == OP_LW) return ACC_LOAD;
    if (op == OP_SW) return ACC_STORE;
    return ACC_NONE;
  endfunction

  // Stores, conditional branches and JR produce no register result.
  function automatic logic op_writes_reg(input logic [5:0] op);
    return !((op == OP_SW) || ((op >= OP_BEQ) && (op <= OP_BGEU)) || (op == OP_JR));
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data memory: single port, asynchronous read, synchronous write.
//  clk   in  clock
//  we    in  write enable (sampled at posedge)
//  addr  in  word address (shared by read and write)
//  wdata in  write data
//  rdata out combinational read data (old contents during a write cycle)
// Contents are never reset.
module dmem_ram #(
  parameter int    DW   = 32,
  parameter int    AW   = 14,
  parameter string INIT = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: performs LW/SW on the data memory, registers the result
// into the MEM latch for WB, and drives a same-cycle bypass bus to decode.
// Optional feature macro: MEM_MMIO_EN (memory-mapped HEX/LEDR/KEY page at
// 0xFFFFF000; adds ports key_in, hex_out, ledr_out).
//  clk, reset           clock, synchronous active-high reset
//  agex_*               AGEX latch fields (valid, op, rd, arith, memaddr, pc, icount)
//  mem_*                MEM latch outputs (1-cycle latency)
//  fwd_wr/fwd_rd/fwd_val combinational bypass of the op currently entering MEM
//  misalign_cnt         saturating count of misaligned valid LW/SW
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int    DBITS     = 32,
  parameter int    REGNOBITS = 5,
  parameter int    IOPBITS   = 6,
  parameter int    DMEM_AW   = 14,
  parameter string DMEM_INIT = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 agex_valid,
  input  logic [IOPBITS-1:0]   agex_op,
  input  logic [REGNOBITS-1:0] agex_rd,
  input  logic [DBITS-1:0]     agex_arith,
  input  logic [DBITS-1:0]     agex_memaddr,
  input  logic [DBITS-1:0]     agex_pc,
  input  logic [DBITS-1:0]     agex_icount,
  output logic                 mem_valid,
  output logic                 mem_wr_reg,
  output logic [REGNOBITS-1:0] mem_rd,
  output logic [DBITS-1:0]     mem_result,
  output logic [DBITS-1:0]     mem_pc,
  output logic [DBITS-1:0]     mem_icount,
  output logic                 fwd_wr,
  output logic [REGNOBITS-1:0] fwd_rd,
  output logic [DBITS-1:0]     fwd_val,
  output logic [7:0]           misalign_cnt
`ifdef MEM_MMIO_EN
  ,
  input  logic [3:0]           key_in,
  output logic [23:0]          hex_out,
  output logic [9:0]           ledr_out
`endif
);

  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic [REGNOBITS-1:0] rd;
    logic [DBITS-1:0]     result;
    logic [DBITS-1:0]     pc;
    logic [DBITS-1:0]     icount;
  } mem_latch_t;

  logic [5:0]         op;
  mem_acc_e           acc;
  logic               is_ld, is_st, wr, misaligned;
  logic [DMEM_AW-1:0] widx;
  logic               ram_we;
  logic [DBITS-1:0]   ram_rdata, load_data, result;
  mem_latch_t         lat;
  logic [7:0]         cnt;
  logic               unused_addr;

  assign op    = 6'(agex_op);
  assign acc   = mem_acc(op);
  assign is_ld = (acc == ACC_LOAD);
  assign is_st = (acc == ACC_STORE);
  assign wr    = agex_valid & (agex_rd != '0) & op_writes_reg(op);
  // Upper address bits fall off here: the RAM aliases across the address space.
  assign widx  = agex_memaddr[DMEM_AW+1:2];
  assign misaligned  = agex_valid & (is_ld | is_st) & (agex_memaddr[1:0] != 2'b00);
  assign unused_addr = ^agex_memaddr[DBITS-1:DMEM_AW+2];

`ifdef MEM_MMIO_EN
  logic             mmio_hit;
  mmio_sel_e        mmio_sel;
  logic [DBITS-1:0] mmio_rdata;
  logic [3:0]       key_s1, key_s2;
  logic [23:0]      hex_q;
  logic [9:0]       ledr_q;

  assign mmio_hit = (agex_memaddr[31:12] == MMIO_PAGE);

  always_comb begin
    mmio_sel = MMIO_NONE;
    if (mmio_hit) begin
      case (agex_memaddr[11:2])
        MMIO_HEX_WOFS:  mmio_sel = MMIO_HEX;
        MMIO_LEDR_WOFS: mmio_sel = MMIO_LEDR;
        MMIO_KEY_WOFS:  mmio_sel = MMIO_KEY;
        default:        mmio_sel = MMIO_NONE;
      endcase
    end
  end

  always_comb begin
    mmio_rdata = '0;
    case (mmio_sel)
      MMIO_HEX:  mmio_rdata = DBITS'(hex_q);
      MMIO_LEDR: mmio_rdata = DBITS'(ledr_q);
      MMIO_KEY:  mmio_rdata = DBITS'(key_s2);
      default:   mmio_rdata = '0;
    endcase
  end

  // KEY is asynchronous to clk; two flops before it is visible to loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
      hex_q  <= '0;
      ledr_q <= '0;
    end else begin
      key_s1 <= key_in;
      key_s2 <= key_s1;
      if (agex_valid && is_st && mmio_sel == MMIO_HEX)  hex_q  <= agex_arith[23:0];
      if (agex_valid && is_st && mmio_sel == MMIO_LEDR) ledr_q <= agex_arith[9:0];
    end
  end

  assign hex_out   = hex_q;
  assign ledr_out  = ledr_q;
  assign ram_we    = agex_valid & is_st & ~mmio_hit & ~reset;
  assign load_data = mmio_hit ? mmio_rdata : ram_rdata;
`else
  assign ram_we    = agex_valid & is_st & ~reset;
  assign load_data = ram_rdata;
`endif

  dmem_ram #(
    .DW   (DBITS),
    .AW   (DMEM_AW),
    .INIT (DMEM_INIT)
  ) u_dmem (
    .clk   (clk),
    .we    (ram_we),
    .addr  (widx),
    .wdata (agex_arith),
    .rdata (ram_rdata)
  );

  assign result  = is_ld ? load_data : agex_arith;
  assign fwd_wr  = wr;
  assign fwd_rd  = agex_rd;
  assign fwd_val = result;

  always_ff @(posedge clk) begin
    if (reset) lat <= '0;
    else       lat <= '{valid: agex_valid, wr: wr, rd: agex_rd, result: result,
                        pc: agex_pc, icount: agex_icount};
  end

  always_ff @(posedge clk) begin
    if (reset)                           cnt <= '0;
    else if (misaligned && cnt != 8'hFF) cnt <= cnt + 8'd1;
  end

  assign mem_valid    = lat.valid;
  assign mem_wr_reg   = lat.wr;
  assign mem_rd       = lat.rd;
  assign mem_result   = lat.result;
  assign mem_pc       = lat.pc;
  assign mem_icount   = lat.icount;
  assign misalign_cnt = cnt;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        agex_valid = 1'b0;
  logic [5:0]  agex_op = '0;
  logic [4:0]  agex_rd = '0;
  logic [31:0] agex_arith = '0, agex_memaddr = '0, agex_pc = '0, agex_icount = '0;
  logic        mem_valid, mem_wr_reg, fwd_wr;
  logic [4:0]  mem_rd, fwd_rd;
  logic [31:0] mem_result, mem_pc, mem_icount, fwd_val;
  logic [7:0]  misalign_cnt;
`ifdef MEM_MMIO_EN
  logic [3:0]  key_in = '0;
  logic [23:0] hex_out;
  logic [9:0]  ledr_out;
`endif

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .agex_valid(agex_valid), .agex_op(agex_op), .agex_rd(agex_rd),
    .agex_arith(agex_arith), .agex_memaddr(agex_memaddr), .agex_pc(agex_pc),
    .agex_icount(agex_icount), .mem_valid(mem_valid), .mem_wr_reg(mem_wr_reg), .mem_rd(mem_rd),
    .mem_result(mem_result), .mem_pc(mem_pc), .mem_icount(mem_icount), .fwd_wr(fwd_wr),
    .fwd_rd(fwd_rd), .fwd_val(fwd_val), .misalign_cnt(misalign_cnt)
`ifdef MEM_MMIO_EN
    , .key_in(key_in), .hex_out(hex_out), .ledr_out(ledr_out)
`endif
  );

  int checks = 0, errors = 0;

  // Reference model: sparse word memory, misalign counter, expected outputs.
  logic [31:0] mmem [int];
  int          m_cnt = 0;
  logic        e_wr, e_known, l_valid, l_wr, l_known;
  logic [4:0]  l_rd;
  logic [31:0] e_val, l_result, l_pc, l_ic;

  // Drive one op at the negedge and compute what the stage should do with it.
  task automatic drive(input bit rst, input logic v, input logic [5:0] op, input logic [4:0] rd,
                       input logic [31:0] arith, input logic [31:0] addr,
                       input logic [31:0] pc, input logic [31:0] ic);
    int  w;
    bit  ld, st, nowr;
    @(negedge clk);
    reset = rst; agex_valid = v; agex_op = op; agex_rd = rd;
    agex_arith = arith; agex_memaddr = addr; agex_pc = pc; agex_icount = ic;
    w    = int'((addr >> 2) % 16384);
    ld   = (op == OP_LW);
    st   = (op == OP_SW);
    nowr = st || op == OP_BEQ || op == OP_BNE || op == OP_BLT || op == OP_BGE ||
           op == OP_BLTU || op == OP_BGEU || op == OP_JR;
    e_wr    = v && rd != 0 && !nowr;
    e_known = !ld || mmem.exists(w);
    e_val   = !ld ? arith : (mmem.exists(w) ? mmem[w] : 32'h0);
    if (rst) begin
      {l_valid, l_wr, l_rd, l_result, l_pc, l_ic} = '0;
      l_known = 1'b1;
      m_cnt = 0;
    end else begin
      l_valid = v; l_wr = e_wr; l_rd = rd; l_result = e_val; l_pc = pc; l_ic = ic;
      l_known = e_known;
      if (v && st) mmem[w] = arith;
      if (v && (ld || st) && addr[1:0] != 0 && m_cnt < 255) m_cnt++;
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1'b1, (i == 0) ? OP_SW : OP_LW, 5'(i + 9), $urandom, 32'h0000_0103,
            $urandom, $urandom);
      tick();
      checks++; if (mem_valid !== 1'b0)  begin errors++; $display("FAIL reset.mem_valid got %0d want 0", mem_valid); end
      checks++; if (mem_wr_reg !== 1'b0) begin errors++; $display("FAIL reset.mem_wr_reg got %0d want 0", mem_wr_reg); end
      checks++; if ({mem_rd, mem_result, mem_pc, mem_icount} !== '0)
        begin errors++; $display("FAIL reset.latch got rd %h res %h pc %h ic %h want 0", mem_rd, mem_result, mem_pc, mem_icount); end
      checks++; if (misalign_cnt !== 8'd0) begin errors++; $display("FAIL reset.misalign_cnt got %0d want 0", misalign_cnt); end
    end
  endtask

  task automatic test_sw_lw();
    drive(0, 1'b1, OP_SW, 5'd0, 32'hDEADBEEF, 32'h100, 32'h40, 32'd1);
    checks++; if (fwd_wr !== 1'b0) begin errors++; $display("FAIL sw.fwd_wr got %0d want 0", fwd_wr); end
    tick();
    drive(0, 1'b1, OP_LW, 5'd3, 32'h0, 32'h100, 32'h44, 32'd2);
    checks++; if (fwd_val !== 32'hDEADBEEF) begin errors++; $display("FAIL lw.fwd_val got %h want deadbeef", fwd_val); end
    checks++; if (fwd_wr !== 1'b1 || fwd_rd !== 5'd3) begin errors++; $display("FAIL lw.fwd_wr_rd got %0d/%0d want 1/3", fwd_wr, fwd_rd); end
    tick();
    checks++; if (mem_result !== 32'hDEADBEEF) begin errors++; $display("FAIL lw.mem_result got %h want deadbeef", mem_result); end
    checks++; if (mem_wr_reg !== 1'b1 || mem_rd !== 5'd3 || mem_valid !== 1'b1)
      begin errors++; $display("FAIL lw.mem_ctl got wr %0d rd %0d v %0d want 1 3 1", mem_wr_reg, mem_rd, mem_valid); end
    checks++; if (mem_pc !== 32'h44 || mem_icount !== 32'd2)
      begin errors++; $display("FAIL lw.passthru got pc %h ic %0d want 44 2", mem_pc, mem_icount); end
  endtask

  task automatic test_invalid_sw();
    drive(0, 1'b1, OP_SW, 5'd0, 32'h0000_0055, 32'h200, 32'h50, 32'd3);
    tick();
    drive(0, 1'b0, OP_SW, 5'd0, 32'h0000_1234, 32'h200, 32'h54, 32'd4);
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL inv_sw.mem_valid got %0d want 0", mem_valid); end
    drive(0, 1'b1, OP_LW, 5'd6, 32'h0, 32'h200, 32'h58, 32'd5);
    checks++; if (fwd_val !== 32'h0000_0055) begin errors++; $display("FAIL inv_sw.fwd_val got %h want 55", fwd_val); end
    tick();
    checks++; if (mem_result !== 32'h0000_0055) begin errors++; $display("FAIL inv_sw.mem_result got %h want 55", mem_result); end
  endtask

  task automatic test_alu();
    logic [5:0] ops [4] = '{OP_ADD, OP_ADD, OP_BEQ, OP_JR};
    logic [4:0] rds [4] = '{5'd5, 5'd0, 5'd5, 5'd5};
    logic       wrs [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, ops[i], rds[i], 32'd7, $urandom, 32'h60, 32'd6);
      tick();
      checks++; if (mem_result !== 32'd7) begin errors++; $display("FAIL alu%0d.mem_result got %h want 7", i, mem_result); end
      checks++; if (mem_wr_reg !== wrs[i]) begin errors++; $display("FAIL alu%0d.mem_wr_reg got %0d want %0d", i, mem_wr_reg, wrs[i]); end
    end
  endtask

  task automatic test_random();
    logic [5:0]  pool_ops [11] = '{OP_ADD, OP_SUB, OP_AND, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BGEU,
                                   OP_JR, OP_JAL, OP_LW};
    logic [13:0] words [8];
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      words[i] = 14'($urandom);
      drive(0, 1'b1, OP_SW, 5'd0, $urandom, {18'd0, words[i]} << 2, 32'h0, 32'h0);
      tick();
    end
    for (int n = 0; n < 400; n++) begin
      a = ($urandom & 32'h7FFF_0000) | ({18'd0, words[$urandom_range(0, 7)]} << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
      drive(0, 1'($urandom_range(0, 5) != 0), pool_ops[$urandom_range(0, 10)], 5'($urandom),
            $urandom, a, $urandom, $urandom);
      checks++; if (fwd_wr !== e_wr || fwd_rd !== agex_rd || (e_known && fwd_val !== e_val))
        begin errors++; $display("FAIL rnd.fwd got %0d/%0d/%h want %0d/%0d/%h", fwd_wr, fwd_rd, fwd_val, e_wr, agex_rd, e_val); end
      tick();
      checks++; if (mem_valid !== l_valid || mem_wr_reg !== l_wr || mem_rd !== l_rd)
        begin errors++; $display("FAIL rnd.ctl got %0d %0d %0d want %0d %0d %0d", mem_valid, mem_wr_reg, mem_rd, l_valid, l_wr, l_rd); end
      checks++; if ((l_known && mem_result !== l_result) || mem_pc !== l_pc || mem_icount !== l_ic)
        begin errors++; $display("FAIL rnd.data got %h %h %h want %h %h %h", mem_result, mem_pc, mem_icount, l_result, l_pc, l_ic); end
      checks++; if (misalign_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rnd.misalign_cnt got %0d want %0d", misalign_cnt, m_cnt); end
    end
  endtask

  task automatic test_midstream_reset();
    drive(0, 1'b1, OP_SW, 5'd0, 32'hAAAA_0001, 32'h300, 32'h70, 32'd7);
    tick();
    drive(0, 1'b1, OP_ADD, 5'd7, 32'd9, 32'h0, 32'h74, 32'd8);
    tick();
    drive(1, 1'b1, OP_SW, 5'd0, 32'hBBBB_0002, 32'h300, 32'h78, 32'd9);
    tick();
    checks++; if (mem_valid !== 1'b0 || mem_result !== 32'h0 || mem_pc !== 32'h0)
      begin errors++; $display("FAIL mid_rst.latch got v %0d res %h pc %h want 0", mem_valid, mem_result, mem_pc); end
    drive(0, 1'b1, OP_LW, 5'd4, 32'h0, 32'h300, 32'h7C, 32'd10);
    checks++; if (fwd_val !== 32'hAAAA_0001) begin errors++; $display("FAIL mid_rst.sw_suppressed got %h want aaaa0001", fwd_val); end
    tick();
  endtask

  task automatic test_misalign();
    logic [31:0] exp_w;
    drive(1, 1'b0, OP_ADD, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checks++; if (misalign_cnt !== 8'd0) begin errors++; $display("FAIL mis.clear got %0d want 0", misalign_cnt); end
    drive(0, 1'b1, OP_SW, 5'd0, 32'hCAFE_F00D, 32'h100, 32'h80, 32'd11);
    tick();
    drive(0, 1'b1, OP_LW, 5'd2, 32'h0, 32'h102, 32'h84, 32'd12);
    checks++; if (fwd_val !== 32'hCAFE_F00D) begin errors++; $display("FAIL mis.trunc_read got %h want cafef00d", fwd_val); end
    tick();
    checks++; if (misalign_cnt !== 8'd1) begin errors++; $display("FAIL mis.count1 got %0d want 1", misalign_cnt); end
    for (int n = 0; n < 300; n++) begin
      drive(0, 1'b1, ($urandom_range(0, 1) != 0) ? OP_LW : OP_SW, 5'($urandom), $urandom,
            32'h100 | 32'($urandom_range(1, 3)), $urandom, $urandom);
      exp_w = e_val;
      tick();
      checks++; if (misalign_cnt !== 8'(m_cnt) || (e_known && mem_result !== exp_w))
        begin errors++; $display("FAIL mis.loop got cnt %0d res %h want %0d %h", misalign_cnt, mem_result, m_cnt, exp_w); end
    end
    checks++; if (misalign_cnt !== 8'd255) begin errors++; $display("FAIL mis.saturate got %0d want 255", misalign_cnt); end
  endtask

`ifdef MEM_MMIO_EN
  task automatic test_mmio();
    drive(0, 1'b1, OP_SW, 5'd0, 32'h0000_0011, 32'h0000_F020, 32'h0, 32'h0);
    tick();
    drive(0, 1'b1, OP_SW, 5'd0, 32'h0000_03FF, 32'hFFFF_F020, 32'h0, 32'h0);
    tick();
    checks++; if (ledr_out !== 10'h3FF) begin errors++; $display("FAIL mmio.ledr got %h want 3ff", ledr_out); end
    drive(0, 1'b1, OP_LW, 5'd1, 32'h0, 32'h0000_F020, 32'h0, 32'h0);
    checks++; if (fwd_val !== 32'h11) begin errors++; $display("FAIL mmio.ram_untouched got %h want 11", fwd_val); end
    tick();
    key_in = 4'hA;
    tick(); tick();
    drive(0, 1'b1, OP_LW, 5'd1, 32'h0, 32'hFFFF_F080, 32'h0, 32'h0);
    tick();
    checks++; if (mem_result !== 32'hA) begin errors++; $display("FAIL mmio.key got %h want a", mem_result); end
  endtask
`endif

  initial begin
    test_reset();
    test_sw_lw();
    test_invalid_sw();
    test_alu();
    test_random();
    test_midstream_reset();
    test_misalign();
`ifdef MEM_MMIO_EN
    test_mmio();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
